decoder_scan_sequencer: RTL and testbench
=========================================

// Module: decoder_scan_sequencer
// PURPOSE
//  Produces the 3-bit select {a,b,c} that drives the 3-to-8 decoder stage
//  (a = MSB), stepping it at a prescaled rate for LED chasers and digit scanning.
//  Supported modes: count up, count down, ping-pong, and hold. A parallel load
//  is available. One-cycle status pulses mark each step and each wrap/reversal.
// PARAMETERS
//  PRESCALE  4   clk cycles per step while enabled; legal range 1..2**PS_W-1
//  PS_W      16  prescaler counter width
// PORTS
//  clk       in   1     single clock; all state updates on rising edge
//  rst_n     in   1     synchronous, active-low reset
//  en        in   1     1 = prescaler runs; 0 = prescaler and code frozen
//  mode      in   2     00 up, 01 down, 10 ping-pong, 11 hold
//  load      in   1     synchronous parallel load of the code
//  load_val  in   3     value loaded into {a,b,c} when load=1
//  a,b,c     out  1 ea  registered select code; a = bit2, c = bit0
//  step      out  1     1-cycle pulse: code changed by a tick in this cycle
//  wrap      out  1     1-cycle pulse: 7->0 (up), 0->7 (down), or ping-pong reversal
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge)
//   - {a,b,c}=000, prescaler=0, dir=up, step=0, wrap=0.
//   - Reset has priority over every other input.
//  Priority order: rst_n > load > en/tick.
//  load=1
//   - Code <= load_val; prescaler <= 0; dir <= up; step=0; wrap=0.
//   - Applies regardless of en and mode.
//  Prescaler (en=1, no load)
//   - Counts 0..PRESCALE-1.
//   - tick = (count==PRESCALE-1); the count then returns to 0.
//   - PRESCALE=1 gives a tick every enabled cycle.
//   - With en held at 1 from reset, the first code change is visible after
//     the PRESCALE-th rising edge.
//  en=0
//   - Prescaler, code, and dir all hold; step=0 and wrap=0.
//  On a tick, by mode
//   - 00 up: code+1 modulo 8; dir <= up; wrap=1 when 7->0.
//   - 01 down: code-1 modulo 8; dir <= down; wrap=1 when 0->7.
//   - 10 ping-pong: moves one step in the direction given by dir.
//     - At 7 with dir=up: dir <= down, code <= 6, wrap=1.
//     - At 0 with dir=down: dir <= up, code <= 1, wrap=1.
//   - 11 hold: code and dir unchanged; step=0; the prescaler keeps running.
//  step=1 only on ticks that change the code (modes 00, 01, 10).
//  step and wrap are registered and appear in the same cycle as the new code.
//  A mode change takes effect at the next tick. The prescaler phase is
//  preserved across the mode change.
//  Entering ping-pong uses the current dir, which was last set by up/down/load.
//  Non-tick cycles: step=0, wrap=0, code unchanged.
//  No combinational path exists from any input to any output.
// TESTING
//  1. Reset, PRESCALE=4, en=1, mode=00 for 33 cycles -> code 0,1..7,0 changes
//     every 4 cycles; step pulses 8x; wrap=1 once, on the 7->0 step.
//  2. load_val=3, load for one cycle, then mode=01 -> codes 3,2,1,0,7;
//     wrap=1 only at 0->7.
//  3. mode=10 from 000 after reset -> 0..7,6..0,1; wrap pulses at the
//     7->6 and 0->1 reversals only.
//  4. en=0 for 10 cycles mid-count at code 5, prescaler=2 -> code stays 5;
//     on resume, the next step comes 2 cycles later (6 at 4th enabled edge total).
//  5. mode=11 for 12 cycles -> no code change, step=0; switching to 00 steps
//     on the existing prescaler phase.
//  6. rst_n=0 for one cycle at code 6 in ping-pong going down, with load=1
//     asserted simultaneously -> code=000, dir=up, step=wrap=0 (reset beats load).

Source files
------------

// File: rtl/decoder_scan_sequencer.sv
// -----------------------------------------------------------------------------
// decoder_scan_sequencer
//
// Purpose:
//   Generates the 3-bit select code {a,b,c} for a 3-to-8 decoder (a = MSB).
//   The code steps at a prescaled rate in one of four modes: count up,
//   count down, ping-pong or hold. A synchronous parallel load is available.
//   One-cycle status pulses mark every code step and every wrap/reversal.
//
// Parameters:
//   PRESCALE : enabled clk cycles per step (1 .. 2**PS_W-1)
//   PS_W     : prescaler counter width
//
// Ports:
//   clk       in   rising-edge clock, all state updates here
//   rst_n     in   synchronous active-low reset (highest priority)
//   en        in   1 = prescaler runs; 0 = prescaler, code and dir frozen
//   mode      in   00 up, 01 down, 10 ping-pong, 11 hold
//   load      in   synchronous parallel load of the code (beats en/tick)
//   load_val  in   value loaded into {a,b,c}
//   a, b, c   out  registered select code (a = bit2, c = bit0)
//   step      out  registered 1-cycle pulse, code changed by a tick
//   wrap      out  registered 1-cycle pulse, 7->0, 0->7 or ping-pong reversal
// -----------------------------------------------------------------------------
module decoder_scan_sequencer #(
  parameter int PRESCALE = 4,
  parameter int PS_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       step,
  output logic       wrap
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] cnt_q, cnt_d;
  logic [2:0]      code_q, code_d;
  dir_e            dir_q, dir_d;
  logic            step_q, step_d;
  logic            wrap_q, wrap_d;
  logic            tick;

  // The tick is only meaningful while enabled; it is gated by en below.
  assign tick = (cnt_q == PS_LAST);

  always_comb begin
    cnt_d  = cnt_q;
    code_d = code_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    wrap_d = 1'b0;

    if (load) begin
      code_d = load_val;
      cnt_d  = '0;
      dir_d  = DIR_UP;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        unique case (mode)
          MODE_UP: begin
            code_d = code_q + 3'd1;
            dir_d  = DIR_UP;
            step_d = 1'b1;
            wrap_d = (code_q == 3'd7);
          end
          MODE_DOWN: begin
            code_d = code_q - 3'd1;
            dir_d  = DIR_DOWN;
            step_d = 1'b1;
            wrap_d = (code_q == 3'd0);
          end
          MODE_PING: begin
            step_d = 1'b1;
            // Reversal bounces off the end value instead of repeating it.
            if (dir_q == DIR_UP) begin
              if (code_q == 3'd7) begin
                code_d = 3'd6;
                dir_d  = DIR_DOWN;
                wrap_d = 1'b1;
              end else begin
                code_d = code_q + 3'd1;
              end
            end else begin
              if (code_q == 3'd0) begin
                code_d = 3'd1;
                dir_d  = DIR_UP;
                wrap_d = 1'b1;
              end else begin
                code_d = code_q - 3'd1;
              end
            end
          end
          default: begin
            // Hold: the prescaler keeps its phase, the code does not move.
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      code_q <= 3'd0;
      dir_q  <= DIR_UP;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      code_q <= code_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign a    = code_q[2];
  assign b    = code_q[1];
  assign c    = code_q[0];
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_decoder_scan_sequencer
//
// Directed stimulus pushes the hand-computed expected step events (edge
// number, new code, wrap flag) into a queue; an independent monitor pops and
// compares each time the DUT pulses step, and flags any expected step whose
// edge has passed without a pulse.
// -----------------------------------------------------------------------------
module tb_decoder_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [2:0] load_val;
  logic       a, b, c, step, wrap;

  decoder_scan_sequencer #(
    .PRESCALE(4),
    .PS_W    (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .load    (load),
    .load_val(load_val),
    .a       (a),
    .b       (b),
    .c       (c),
    .step    (step),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  // Count of rising edges so far; at the following falling edge cyc equals
  // the index of the edge that produced the current outputs.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [2:0] code;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   base;

  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
    end else begin
      $display("check %s: %0d ok (edge %0d)", name, act, cyc);
    end
  endtask

  task automatic expect_step(input int at, input logic [2:0] code, input logic w);
    exp_t e;
    e.at   = at;
    e.code = code;
    e.wrap = w;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step_clk(1);
    chk("reset_code", {29'd0, a, b, c}, 32'd0);
    chk("reset_step", {31'd0, step}, 32'd0);
    chk("reset_wrap", {31'd0, wrap}, 32'd0);
    rst_n = 1'b1;
    base  = cyc;
  endtask

  // Monitor: compare every step pulse against the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_step: no step at edge %0d, expected code %0d wrap %0d",
               e.at, e.code, e.wrap);
    end
    if (step === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_step: step at edge %0d code %0d wrap %0d, expected none",
                 cyc, {a, b, c}, wrap);
      end else begin
        e = exp_q.pop_front();
        if ({a, b, c} !== e.code || wrap !== e.wrap || cyc != e.at) begin
          errors++;
          $display("FAIL step_event: got code %0d wrap %0d at edge %0d, expected code %0d wrap %0d at edge %0d",
                   {a, b, c}, wrap, cyc, e.code, e.wrap, e.at);
        end else begin
          $display("step edge %0d: code %0d wrap %0d ok", cyc, e.code, e.wrap);
        end
      end
    end else if (wrap === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wrap_without_step: wrap=1 step=0 at edge %0d, expected wrap only with step", cyc);
    end
  end

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    mode     = 2'b00;
    load     = 1'b0;
    load_val = 3'd0;
    step_clk(2);

    // Test 1: count up, steps every 4 edges, wrap on 7->0.
    en   = 1'b1;
    mode = 2'b00;
    do_reset();
    for (int k = 1; k <= 8; k++) expect_step(base + 4 * k, 3'(k), k == 8);
    step_clk(33);
    chk("up_final_code", {29'd0, a, b, c}, 32'd0);

    // Test 2: load (with en=0, mid-prescale) then count down 3,2,1,0,7.
    mode = 2'b00;
    en   = 1'b1;
    do_reset();
    step_clk(2);
    en       = 1'b0;
    load     = 1'b1;
    load_val = 3'd3;
    step_clk(1);
    load = 1'b0;
    chk("load_code", {29'd0, a, b, c}, 32'd3);
    chk("load_step", {31'd0, step}, 32'd0);
    en   = 1'b1;
    mode = 2'b01;
    expect_step(base + 3 + 4,  3'd2, 1'b0);
    expect_step(base + 3 + 8,  3'd1, 1'b0);
    expect_step(base + 3 + 12, 3'd0, 1'b0);
    expect_step(base + 3 + 16, 3'd7, 1'b1);
    step_clk(17);

    // Test 3: ping-pong 1..7, 6..0, 1 with wraps at both reversals.
    mode = 2'b10;
    en   = 1'b1;
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      if (k <= 7)       expect_step(base + 4 * k, 3'(k), 1'b0);
      else if (k == 8)  expect_step(base + 4 * k, 3'd6, 1'b1);
      else if (k <= 14) expect_step(base + 4 * k, 3'(14 - k), 1'b0);
      else              expect_step(base + 4 * k, 3'd1, 1'b1);
    end
    step_clk(60);

    // Test 4: freeze at code 5 with prescaler at 2, resume 2 edges to step.
    mode = 2'b00;
    en   = 1'b1;
    do_reset();
    for (int k = 1; k <= 5; k++) expect_step(base + 4 * k, 3'(k), 1'b0);
    expect_step(base + 34, 3'd6, 1'b0);
    expect_step(base + 38, 3'd7, 1'b0);
    expect_step(base + 42, 3'd0, 1'b1);
    expect_step(base + 46, 3'd1, 1'b0);
    step_clk(22);
    en = 1'b0;
    step_clk(10);
    chk("frozen_code", {29'd0, a, b, c}, 32'd5);
    en = 1'b1;
    step_clk(16);

    // Test 5: hold for 12 edges, then up on the preserved prescaler phase.
    mode = 2'b00;
    en   = 1'b1;
    do_reset();
    expect_step(base + 4, 3'd1, 1'b0);
    step_clk(5);
    mode = 2'b11;
    step_clk(12);
    chk("hold_code", {29'd0, a, b, c}, 32'd1);
    mode = 2'b00;
    expect_step(base + 20, 3'd2, 1'b0);
    expect_step(base + 24, 3'd3, 1'b0);
    step_clk(8);

    // Test 6: reset beats load while ping-ponging down at code 6.
    mode = 2'b10;
    en   = 1'b1;
    do_reset();
    for (int k = 1; k <= 7; k++) expect_step(base + 4 * k, 3'(k), 1'b0);
    expect_step(base + 32, 3'd6, 1'b1);
    step_clk(32);
    load     = 1'b1;
    load_val = 3'd5;
    do_reset();
    load = 1'b0;
    // dir must be up again: 0->1 with no wrap (a stale down dir would wrap).
    expect_step(base + 4, 3'd1, 1'b0);
    expect_step(base + 8, 3'd2, 1'b0);
    step_clk(9);

    step_clk(2);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
